// File: rtl/fdiv_ctrl.sv
// Single-precision FP divide sequencer: special-case screen, 25-step
// restoring mantissa divide, normalise with truncation, valid/ready result.
module fdiv_ctrl #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127,
    parameter int QBITS = MAN_W + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     sel_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags
);

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int CNT_W = $clog2(QBITS);
    localparam int ET_W  = EXP_W + 2;

    localparam logic [ET_W-1:0]  BIAS_T = BIAS[ET_W-1:0];
    localparam logic [EXP_W-1:0] EONES  = {EXP_W{1'b1}};
    localparam logic signed [ET_W-1:0] EMAX = $signed({2'b00, EONES});
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(QBITS - 1);
    localparam logic [W-1:0] QNAN =
        {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        NORM,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [MAN_W+1:0]   rem_q, rem_d;
    logic [MAN_W:0]     mb_q, mb_d;
    logic [QBITS-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ET_W-1:0]    exp_q, exp_d;
    logic [W-1:0]       result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               out_valid_q, out_valid_d;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0]   ma, mb;
    logic             sgn;
    logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign ea     = a_q[W-2:MAN_W];
    assign eb     = b_q[W-2:MAN_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];
    assign sgn    = a_q[W-1] ^ b_q[W-1];
    // Subnormals are flushed: exponent zero means the value is zero.
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);
    assign ma     = zero_a ? '0 : {1'b1, fa};
    assign mb     = zero_b ? '0 : {1'b1, fb};
    assign nan_a  = (ea == EONES) && (fa != '0);
    assign nan_b  = (eb == EONES) && (fb != '0);
    assign inf_a  = (ea == EONES) && (fa == '0);
    assign inf_b  = (eb == EONES) && (fb == '0);

    logic           spec_hit;
    logic [W-1:0]   spec_res;
    logic [3:0]     spec_flg;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = '0;
        spec_flg = '0;
        if (nan_a || nan_b) begin
            spec_res = QNAN;
            spec_flg = 4'b1000;
        end else if ((inf_a && inf_b) || (zero_a && zero_b)) begin
            spec_res = QNAN;
            spec_flg = 4'b1000;
        end else if (inf_a) begin
            spec_res = {sgn, EONES, {MAN_W{1'b0}}};
        end else if (zero_b) begin
            spec_res = {sgn, EONES, {MAN_W{1'b0}}};
            spec_flg = 4'b0100;
        end else if (zero_a || inf_b) begin
            spec_res = {sgn, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic             ge;
    logic [MAN_W+1:0] diff;
    logic [MAN_W+1:0] rem_nxt;

    // Remainder stays below twice the divisor, so the shift never overflows.
    assign ge      = (rem_q >= {1'b0, mb_q});
    assign diff    = rem_q - {1'b0, mb_q};
    assign rem_nxt = ge ? {diff[MAN_W:0], 1'b0} : {rem_q[MAN_W:0], 1'b0};

    logic                    lead;
    logic [MAN_W-1:0]        frac_n;
    logic signed [ET_W-1:0]  exp_n;
    logic                    ovf, unf;

    assign lead   = quo_q[QBITS-1];
    assign frac_n = lead ? quo_q[QBITS-2:1] : quo_q[QBITS-3:0];
    assign exp_n  = lead ? $signed(exp_q) : $signed(exp_q - 1'b1);
    assign ovf    = (exp_n >= EMAX);
    assign unf    = (exp_n <= 0);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        rem_d       = rem_q;
        mb_d        = mb_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (spec_hit) begin
                    result_d = spec_res;
                    flags_d  = spec_flg;
                    state_d  = DONE;
                end else begin
                    rem_d   = {1'b0, ma};
                    mb_d    = mb;
                    quo_d   = '0;
                    cnt_d   = CNT_INIT;
                    exp_d   = {2'b00, ea} - {2'b00, eb} + BIAS_T;
                    state_d = DIV;
                end
            end
            DIV: begin
                quo_d = {quo_q[QBITS-2:0], ge};
                rem_d = rem_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = NORM;
            end
            NORM: begin
                if (ovf) begin
                    result_d = {sgn, EONES, {MAN_W{1'b0}}};
                    flags_d  = 4'b0010;
                end else if (unf) begin
                    result_d = {sgn, {(W-1){1'b0}}};
                    flags_d  = 4'b0001;
                end else begin
                    result_d = {sgn, exp_n[EXP_W-1:0], frac_n};
                    flags_d  = 4'b0000;
                end
                state_d = DONE;
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            mb_q        <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            mb_q        <= mb_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign sel_en    = (state_q == CHECK) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Bench for fdiv_ctrl: directed vectors, backpressure, mid-op reset and
// random operands against an arithmetic reference model.
module tb_fdiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    fdiv_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel_en    (sel_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // {special, flags, result} from IEEE rules and integer division.
    function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [7:0]  ex, ey;
        logic [22:0] fx, fy;
        logic        s, nx, ny, ix, iy, zx, zy;
        longint      qq;
        int          e;
        logic [22:0] fr;
        logic [7:0]  e8;
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0];  fy = y[22:0];
        s  = x[31] ^ y[31];
        nx = (ex == 8'hFF) && (fx != 0);
        ny = (ey == 8'hFF) && (fy != 0);
        ix = (ex == 8'hFF) && (fx == 0);
        iy = (ey == 8'hFF) && (fy == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny) return {1'b1, 4'b1000, 32'h7FC00000};
        if ((ix && iy) || (zx && zy)) return {1'b1, 4'b1000, 32'h7FC00000};
        if (ix) return {1'b1, 4'b0000, s, 8'hFF, 23'h0};
        if (zy) return {1'b1, 4'b0100, s, 8'hFF, 23'h0};
        if (zx || iy) return {1'b1, 4'b0000, s, 31'h0};
        qq = (longint'({1'b1, fx}) << 24) / longint'({1'b1, fy});
        e  = int'(ex) - int'(ey) + 127;
        if (qq >= (longint'(1) << 24)) begin
            fr = qq[23:1];
        end else begin
            fr = qq[22:0];
            e  = e - 1;
        end
        if (e >= 255) return {1'b0, 4'b0010, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, 4'b0001, s, 31'h0};
        e8 = e[7:0];
        return {1'b0, 4'b0000, s, e8, fr};
    endfunction

    function automatic logic [31:0] rnd_fp();
        int          r;
        int          e;
        logic [31:0] f;
        logic [7:0]  e8;
        logic        s;
        r = $urandom_range(0, 19);
        f = $urandom;
        if (r == 0) begin
            e = 0;
        end else if (r == 1) begin
            e = 255;
            if ($urandom_range(0, 1) == 1) f = 0;
        end else if (r < 6) begin
            e = $urandom_range(1, 254);
        end else begin
            e = $urandom_range(110, 145);
        end
        e8 = e[7:0];
        s  = ($urandom_range(0, 1) == 1);
        return {s, e8, f[22:0]};
    endfunction

    // Issue one operation, report edges from accept to out_valid (0 = timeout).
    task automatic do_op(input logic [31:0] xa, input logic [31:0] xb,
                         output logic [31:0] r, output logic [3:0] f,
                         output int lat, output logic sel_seen,
                         output logic rdy_busy);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sel_seen = sel_en;
        rdy_busy = in_ready;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        r = result;
        f = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if ({out_valid, sel_en, flags, result} !== 38'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b %h %h exp=0", out_valid, sel_en, flags, result);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va[9], vb[9], vr[9];
        logic [3:0]  vf[9];
        int          vl[9];
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        logic        se, rb;
        va[0]=32'h40C00000; vb[0]=32'h40000000; vr[0]=32'h40400000; vf[0]=4'b0000; vl[0]=28;
        va[1]=32'h3F800000; vb[1]=32'h40400000; vr[1]=32'h3EAAAAAA; vf[1]=4'b0000; vl[1]=28;
        va[2]=32'hC0C00000; vb[2]=32'h40000000; vr[2]=32'hC0400000; vf[2]=4'b0000; vl[2]=28;
        va[3]=32'h3F800000; vb[3]=32'h00000000; vr[3]=32'h7F800000; vf[3]=4'b0100; vl[3]=2;
        va[4]=32'h00000000; vb[4]=32'h00000000; vr[4]=32'h7FC00000; vf[4]=4'b1000; vl[4]=2;
        va[5]=32'h7F000000; vb[5]=32'h3E800000; vr[5]=32'h7F800000; vf[5]=4'b0010; vl[5]=28;
        va[6]=32'h00800000; vb[6]=32'h40000000; vr[6]=32'h00000000; vf[6]=4'b0001; vl[6]=28;
        va[7]=32'hFF800000; vb[7]=32'h3F800000; vr[7]=32'hFF800000; vf[7]=4'b0000; vl[7]=2;
        va[8]=32'h3F800000; vb[8]=32'hFF800000; vr[8]=32'h80000000; vf[8]=4'b0000; vl[8]=2;
        for (int i = 0; i < 9; i++) begin
            do_op(va[i], vb[i], r, f, lat, se, rb);
            checks++;
            if (r !== vr[i]) begin
                errors++;
                $display("FAIL dir%0d_result got=%h exp=%h", i, r, vr[i]);
            end
            checks++;
            if (f !== vf[i]) begin
                errors++;
                $display("FAIL dir%0d_flags got=%b exp=%b", i, f, vf[i]);
            end
            checks++;
            if (lat !== vl[i]) begin
                errors++;
                $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, vl[i]);
            end
            checks++;
            if ({se, rb} !== 2'b10) begin
                errors++;
                $display("FAIL dir%0d_check_cycle sel_en/in_ready got=%b%b exp=10", i, se, rb);
            end
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL dir%0d_after_consume valid/ready got=%b%b exp=01", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid_timeout got=%b exp=1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({out_valid, in_ready, result} !== {2'b10, 32'h40400000}) begin
                errors++;
                $display("FAIL bp_hold%0d valid/ready/result got=%b%b %h exp=10 40400000",
                         i, out_valid, in_ready, result);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release valid/ready got=%b%b exp=01", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic        seen;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        logic        se, rb;
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_after valid/ready got=%b%b exp=01", out_valid, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_output got=%b exp=0", seen);
        end
        do_op(32'h3F800000, 32'h40400000, r, f, lat, se, rb);
        checks++;
        if ({r, f} !== {32'h3EAAAAAA, 4'b0000} || lat != 28) begin
            errors++;
            $display("FAIL rst_mid_next_op got=%h %b lat=%0d exp=3eaaaaaa 0000 lat=28", r, f, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, r;
        logic [3:0]  f;
        logic [36:0] m;
        int          lat, el;
        logic        se, rb;
        for (int i = 0; i < 60; i++) begin
            x = rnd_fp();
            y = rnd_fp();
            m = model(x, y);
            el = m[36] ? 2 : 28;
            do_op(x, y, r, f, lat, se, rb);
            checks++;
            if ({f, r} !== m[35:0] || lat != el) begin
                errors++;
                $display("FAIL rnd%0d a=%h b=%h got=%h %b lat=%0d exp=%h %b lat=%0d",
                         i, x, y, r, f, lat, m[31:0], m[35:32], el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
